audio_sample_framer: RTL and testbench
======================================

AUDIO_SAMPLE_FRAMER -- requirements
Module: audio_sample_framer

Interface
REQ-001 SHALL have parameter WD, default 24, meaning audio sample width per channel.
REQ-002 SHALL have parameter DEPTH, default 4 (power of 2, >=2), meaning frames per FIFO.
REQ-003 SHALL have port clk_i  input  1  system clock (12 MHz); one clock for the whole block.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port lrck_i  input  1  sample clock from codec interface (high = left period).
REQ-007 SHALL have port adc_pdata_i  input  WD  parallel ADC word from codec interface.
REQ-008 SHALL have port dac_pdata_o  output  WD  parallel DAC word to codec interface.
REQ-009 SHALL have ports rx_valid_o output 1, rx_ready_i input 1, rx_left_o output WD, rx_right_o output WD: captured stereo frame stream.
REQ-010 SHALL have ports tx_valid_i input 1, tx_ready_o output 1, tx_left_i input WD, tx_right_i input WD: playback stereo frame stream.
REQ-011 SHALL have ports rx_overflow_o output 1, tx_underflow_o output 1 (sticky flags), clr_status_i input 1 (clears both).

Function
REQ-012 SHALL register lrck_i into lrck_q when en_i=1; rise = lrck_i & ~lrck_q, fall = ~lrck_i & lrck_q; no edge detected while en_i=0.
REQ-013 On fall, SHALL latch adc_pdata_i into left_hold and set have_left.
REQ-014 On rise with have_left=1, SHALL push frame {left_hold, adc_pdata_i} into RX FIFO and clear have_left; rise with have_left=0 pushes nothing.
REQ-015 RX FIFO SHALL be DEPTH entries, first-word-fall-through: rx_valid_o = not empty; rx_left_o/rx_right_o show head frame.
REQ-016 RX pop SHALL occur on rx_valid_o & rx_ready_i; head data stable while rx_valid_o=1 and no pop.
REQ-017 RX push when full and no same-cycle pop SHALL drop the new frame, keep contents, set rx_overflow_o.
REQ-018 RX push and pop in same cycle when full SHALL both take effect; no overflow.
REQ-019 TX FIFO SHALL be DEPTH entries; tx_ready_o = not full; push on tx_valid_i & tx_ready_o; push and pop same cycle when full: pop first, push accepted only if tx_ready_o was 1.
REQ-020 On rise, SHALL pop TX head into cur_left/cur_right; if TX empty, cur_left/cur_right hold previous frame and tx_underflow_o set.
REQ-021 dac_pdata_o SHALL be registered: cur_left while lrck_q=1, cur_right while lrck_q=0, updated each enabled cycle (1-cycle latency from lrck_q).
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1, never exceeds DEPTH nor underflows.
REQ-023 clr_status_i=1 SHALL clear both sticky flags; a same-cycle set event SHALL win over clear.
REQ-024 clr_status_i and stream handshakes SHALL be ignored while en_i=0.

Reset
REQ-025 On rst_ni=0, SHALL asynchronously clear: lrck_q, have_left, left_hold, cur_left, cur_right, both FIFO pointers/counts, dac_pdata_o, rx_overflow_o, tx_underflow_o.
REQ-026 After reset, rx_valid_o=0, tx_ready_o=1, rx_left_o/rx_right_o=0, dac_pdata_o=0.
REQ-027 Reset mid-frame SHALL discard any partial frame; first rise after reset produces no RX push.

Verification
REQ-028 Capture: lrck_i 1->0 with adc=24'h123456, then 0->1 with adc=24'hABCDEF -> one cycle after rise rx_valid_o=1, rx_left_o=123456, rx_right_o=ABCDEF.
REQ-029 Overflow: rx_ready_i=0, 5 complete lrck periods with DEPTH=4 -> 4 frames retained in order, 5th dropped, rx_overflow_o=1 until clr_status_i.
REQ-030 Playback: push tx frame (L=24'h000111, R=24'h000222), then lrck rise -> dac_pdata_o=000111 while lrck high, 000222 after next fall.
REQ-031 Underflow: TX empty at lrck rise after frame (L=5,R=6) played -> dac_pdata_o repeats 5/6, tx_underflow_o=1.
REQ-032 Freeze/reset: en_i=0 across an lrck edge -> no push/pop, no flag change; rst_ni pulse mid-period -> all outputs zero, next rise pushes nothing.

Source files
------------

// File: rtl/audio_sample_framer.sv
// Packs codec left/right words into stereo frames for capture and unpacks
// playback frames back onto the codec DAC word, with a small FIFO each way.
module audio_sample_framer #(
  parameter int WD    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          lrck_i,
  input  logic [WD-1:0] adc_pdata_i,
  output logic [WD-1:0] dac_pdata_o,
  output logic          rx_valid_o,
  input  logic          rx_ready_i,
  output logic [WD-1:0] rx_left_o,
  output logic [WD-1:0] rx_right_o,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  input  logic [WD-1:0] tx_left_i,
  input  logic [WD-1:0] tx_right_i,
  output logic          rx_overflow_o,
  output logic          tx_underflow_o,
  input  logic          clr_status_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef logic [2*WD-1:0] frame_t;

  logic          lrck_q, lrck_d;
  logic          have_left_q, have_left_d;
  logic [WD-1:0] left_hold_q, left_hold_d;
  logic [WD-1:0] cur_left_q, cur_left_d;
  logic [WD-1:0] cur_right_q, cur_right_d;
  logic [WD-1:0] dac_q, dac_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;

  frame_t rx_mem_q [DEPTH];
  frame_t tx_mem_q [DEPTH];
  frame_t rx_head, tx_head;

  logic rise, fall;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_pop, rx_push_req, rx_push, tx_push, tx_pop;

  assign rise     = en_i & lrck_i & ~lrck_q;
  assign fall     = en_i & ~lrck_i & lrck_q;
  assign rx_full  = (rx_cnt_q == FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_head  = rx_mem_q[rx_rd_q];
  assign tx_head  = tx_mem_q[tx_rd_q];

  // A full RX FIFO still accepts a frame when the head leaves in the same cycle.
  assign rx_pop      = en_i & ~rx_empty & rx_ready_i;
  assign rx_push_req = rise & have_left_q;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign tx_push     = en_i & tx_valid_i & ~tx_full;
  assign tx_pop      = rise & ~tx_empty;

  always_comb begin
    lrck_d      = lrck_q;
    have_left_d = have_left_q;
    left_hold_d = left_hold_q;
    cur_left_d  = cur_left_q;
    cur_right_d = cur_right_q;
    dac_d       = dac_q;
    rx_wr_d     = rx_wr_q;
    rx_rd_d     = rx_rd_q;
    tx_wr_d     = tx_wr_q;
    tx_rd_d     = tx_rd_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    rx_ovf_d    = rx_ovf_q;
    tx_unf_d    = tx_unf_q;
    if (en_i) begin
      lrck_d = lrck_i;
      dac_d  = lrck_q ? cur_left_q : cur_right_q;
      if (fall) begin
        left_hold_d = adc_pdata_i;
        have_left_d = 1'b1;
      end
      if (rx_push_req) have_left_d = 1'b0;
      if (tx_pop) {cur_left_d, cur_right_d} = tx_head;
      if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
      if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      // Clearing first lets a same-cycle set event win.
      if (clr_status_i) begin
        rx_ovf_d = 1'b0;
        tx_unf_d = 1'b0;
      end
      if (rx_push_req & ~rx_push) rx_ovf_d = 1'b1;
      if (rise & tx_empty)        tx_unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lrck_q      <= 1'b0;
      have_left_q <= 1'b0;
      left_hold_q <= '0;
      cur_left_q  <= '0;
      cur_right_q <= '0;
      dac_q       <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      tx_unf_q    <= 1'b0;
    end else begin
      lrck_q      <= lrck_d;
      have_left_q <= have_left_d;
      left_hold_q <= left_hold_d;
      cur_left_q  <= cur_left_d;
      cur_right_q <= cur_right_d;
      dac_q       <= dac_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_unf_q    <= tx_unf_d;
    end
  end

  // Frame storage needs no reset; the outputs below mask it while empty.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= {left_hold_q, adc_pdata_i};
    if (tx_push) tx_mem_q[tx_wr_q] <= {tx_left_i, tx_right_i};
  end

  assign rx_valid_o     = ~rx_empty;
  assign rx_left_o      = rx_empty ? '0 : rx_head[2*WD-1:WD];
  assign rx_right_o     = rx_empty ? '0 : rx_head[WD-1:0];
  assign tx_ready_o     = ~tx_full;
  assign dac_pdata_o    = dac_q;
  assign rx_overflow_o  = rx_ovf_q;
  assign tx_underflow_o = tx_unf_q;

endmodule

// File: tb/tb_audio_sample_framer.sv
// Drives audio_sample_framer with directed codec scenarios and random traffic,
// comparing every cycle against a queue-based frame model.
module tb_audio_sample_framer;

  localparam int WD    = 24;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          lrck_i;
  logic [WD-1:0] adc_pdata_i;
  logic [WD-1:0] dac_pdata_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic [WD-1:0] rx_left_o;
  logic [WD-1:0] rx_right_o;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [WD-1:0] tx_left_i;
  logic [WD-1:0] tx_right_i;
  logic          rx_overflow_o;
  logic          tx_underflow_o;
  logic          clr_status_i;

  always #5 clk_i = ~clk_i;

  audio_sample_framer #(.WD(WD), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .lrck_i         (lrck_i),
    .adc_pdata_i    (adc_pdata_i),
    .dac_pdata_o    (dac_pdata_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .rx_left_o      (rx_left_o),
    .rx_right_o     (rx_right_o),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .tx_left_i      (tx_left_i),
    .tx_right_i     (tx_right_i),
    .rx_overflow_o  (rx_overflow_o),
    .tx_underflow_o (tx_underflow_o),
    .clr_status_i   (clr_status_i)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: frames held as plain queues, codec state as simple variables.
  logic [2*WD-1:0] m_rxq[$];
  logic [2*WD-1:0] m_txq[$];
  logic            m_lrck, m_have_left, m_ovf, m_unf;
  logic [WD-1:0]   m_left_hold, m_cur_l, m_cur_r, m_dac;

  task automatic checkOutput(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_rxq.delete();
    m_txq.delete();
    m_lrck = 1'b0; m_have_left = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_left_hold = '0; m_cur_l = '0; m_cur_r = '0; m_dac = '0;
  endtask

  task automatic modelStep();
    logic rise, fall;
    logic [WD-1:0] next_dac;
    int rx_n, tx_n;
    bit rx_pop, tx_push;
    bit ovf_set = 1'b0;
    bit unf_set = 1'b0;
    if (!en_i) return;
    rise     = lrck_i && !m_lrck;
    fall     = !lrck_i && m_lrck;
    next_dac = m_lrck ? m_cur_l : m_cur_r;
    rx_n     = m_rxq.size();
    tx_n     = m_txq.size();
    rx_pop   = (rx_n > 0) && rx_ready_i;
    tx_push  = tx_valid_i && (tx_n < DEPTH);
    if (rx_pop) void'(m_rxq.pop_front());
    if (rise && m_have_left) begin
      if (rx_n < DEPTH || rx_pop) m_rxq.push_back({m_left_hold, adc_pdata_i});
      else ovf_set = 1'b1;
      m_have_left = 1'b0;
    end
    if (rise) begin
      if (tx_n > 0) {m_cur_l, m_cur_r} = m_txq.pop_front();
      else unf_set = 1'b1;
    end
    if (tx_push) m_txq.push_back({tx_left_i, tx_right_i});
    if (fall) begin
      m_left_hold = adc_pdata_i;
      m_have_left = 1'b1;
    end
    if (clr_status_i) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    if (unf_set) m_unf = 1'b1;
    m_lrck = lrck_i;
    m_dac  = next_dac;
  endtask

  // Inputs are already set; advance the model to match the coming edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk_i);
    #2;
  endtask

  task automatic driveLrck(input logic lrck, input logic [WD-1:0] adc);
    lrck_i      = lrck;
    adc_pdata_i = adc;
    applyStimulus();
  endtask

  task automatic lrckPeriod(input logic [WD-1:0] left, input logic [WD-1:0] right);
    driveLrck(1'b0, left);
    driveLrck(1'b0, left);
    driveLrck(1'b1, right);
    driveLrck(1'b1, right);
  endtask

  task automatic resetPulse();
    en_i   = 1'b0;
    rst_ni = 1'b0;
    modelReset();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  always @(posedge clk_i) begin : compare
    logic [2*WD-1:0] head;
    #1;
    if (check_en) begin
      head = (m_rxq.size() > 0) ? m_rxq[0] : '0;
      checkOutput("rx_valid", rx_valid_o, m_rxq.size() > 0);
      checkOutput("rx_left", rx_left_o, head[2*WD-1:WD]);
      checkOutput("rx_right", rx_right_o, head[WD-1:0]);
      checkOutput("tx_ready", tx_ready_o, m_txq.size() < DEPTH);
      checkOutput("dac", dac_pdata_o, m_dac);
      checkOutput("rx_overflow", rx_overflow_o, m_ovf);
      checkOutput("tx_underflow", tx_underflow_o, m_unf);
    end
  end

  initial begin
    int rx_bias, tx_bias;
    en_i = 1'b0; lrck_i = 1'b0; adc_pdata_i = '0; rx_ready_i = 1'b0;
    tx_valid_i = 1'b0; tx_left_i = '0; tx_right_i = '0; clr_status_i = 1'b0;
    rst_ni = 1'b0;
    check_en = 1'b1;
    resetPulse();
    en_i = 1'b1;
    checkOutput("reset rx_valid", rx_valid_o, 1'b0);
    checkOutput("reset tx_ready", tx_ready_o, 1'b1);
    checkOutput("reset rx_left", rx_left_o, 24'h0);
    checkOutput("reset dac", dac_pdata_o, 24'h0);

    // Capture of one frame; the initial rise has no left word and pushes nothing.
    driveLrck(1'b1, 24'h0);
    checkOutput("orphan rise", rx_valid_o, 1'b0);
    driveLrck(1'b0, 24'h123456);
    driveLrck(1'b1, 24'hABCDEF);
    checkOutput("capture valid", rx_valid_o, 1'b1);
    checkOutput("capture left", rx_left_o, 24'h123456);
    checkOutput("capture right", rx_right_o, 24'hABCDEF);

    // Overflow: five frames into a four-deep FIFO with no consumer.
    rx_ready_i = 1'b1;
    driveLrck(1'b1, 24'h0);
    rx_ready_i = 1'b0;
    checkOutput("drain empty", rx_valid_o, 1'b0);
    clr_status_i = 1'b1;
    driveLrck(1'b1, 24'h0);
    clr_status_i = 1'b0;
    checkOutput("clr underflow", tx_underflow_o, 1'b0);
    for (int i = 0; i < 5; i++) lrckPeriod(24'h100 + WD'(i), 24'h200 + WD'(i));
    checkOutput("overflow set", rx_overflow_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf order left %0d", i), rx_left_o, 24'h100 + WD'(i));
      checkOutput($sformatf("ovf order right %0d", i), rx_right_o, 24'h200 + WD'(i));
      rx_ready_i = 1'b1;
      driveLrck(1'b1, 24'h0);
      rx_ready_i = 1'b0;
    end
    checkOutput("fifth dropped", rx_valid_o, 1'b0);
    checkOutput("overflow sticky", rx_overflow_o, 1'b1);
    clr_status_i = 1'b1;
    driveLrck(1'b1, 24'h0);
    clr_status_i = 1'b0;
    checkOutput("overflow cleared", rx_overflow_o, 1'b0);

    // Playback of one frame.
    tx_left_i = 24'h000111; tx_right_i = 24'h000222; tx_valid_i = 1'b1;
    driveLrck(1'b1, 24'h0);
    tx_valid_i = 1'b0;
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b1, 24'h0);
    driveLrck(1'b1, 24'h0);
    checkOutput("play left", dac_pdata_o, 24'h000111);
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b0, 24'h0);
    checkOutput("play right", dac_pdata_o, 24'h000222);
    checkOutput("play no underflow", tx_underflow_o, 1'b0);

    // Underflow repeats the previous frame.
    tx_left_i = 24'h5; tx_right_i = 24'h6; tx_valid_i = 1'b1;
    driveLrck(1'b0, 24'h0);
    tx_valid_i = 1'b0;
    driveLrck(1'b1, 24'h0);
    driveLrck(1'b1, 24'h0);
    checkOutput("frame5 left", dac_pdata_o, 24'h5);
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b0, 24'h0);
    checkOutput("frame5 right", dac_pdata_o, 24'h6);
    driveLrck(1'b1, 24'h0);
    driveLrck(1'b1, 24'h0);
    checkOutput("repeat left", dac_pdata_o, 24'h5);
    checkOutput("underflow set", tx_underflow_o, 1'b1);
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b0, 24'h0);
    checkOutput("repeat right", dac_pdata_o, 24'h6);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) driveLrck(1'b0, 24'h0);
    rx_ready_i = 1'b0;
    checkOutput("rx drained", rx_valid_o, 1'b0);

    // Freeze across lrck edges with handshakes and clear asserted.
    en_i = 1'b0; rx_ready_i = 1'b1; tx_valid_i = 1'b1; tx_left_i = 24'h7; clr_status_i = 1'b1;
    driveLrck(1'b1, 24'h999);
    driveLrck(1'b0, 24'h999);
    driveLrck(1'b1, 24'h999);
    checkOutput("freeze rx_valid", rx_valid_o, 1'b0);
    checkOutput("freeze underflow", tx_underflow_o, 1'b1);
    checkOutput("freeze dac", dac_pdata_o, 24'h6);
    en_i = 1'b1; rx_ready_i = 1'b0; tx_valid_i = 1'b0; clr_status_i = 1'b0;
    driveLrck(1'b1, 24'h999);
    checkOutput("thaw push", rx_valid_o, 1'b1);
    checkOutput("thaw left", rx_left_o, 24'h0);
    checkOutput("thaw right", rx_right_o, 24'h999);

    // Reset in the middle of a frame discards the half-captured left word.
    driveLrck(1'b0, 24'h555);
    rst_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset rx_valid", rx_valid_o, 1'b0);
    checkOutput("midreset rx_left", rx_left_o, 24'h0);
    checkOutput("midreset dac", dac_pdata_o, 24'h0);
    checkOutput("midreset underflow", tx_underflow_o, 1'b0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    driveLrck(1'b0, 24'h0);
    driveLrck(1'b1, 24'h777);
    checkOutput("post-reset rise", rx_valid_o, 1'b0);

    // Random traffic in phases of differing back-pressure and supply.
    rx_bias = 50;
    tx_bias = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 300 == 0) begin
        rx_bias = $urandom_range(0, 2) * 45 + 5;
        tx_bias = $urandom_range(0, 2) * 45 + 5;
      end
      if ($urandom_range(0, 999) == 0) resetPulse();
      en_i         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) lrck_i = ~lrck_i;
      adc_pdata_i  = WD'($urandom);
      rx_ready_i   = ($urandom_range(0, 99) < rx_bias);
      tx_valid_i   = ($urandom_range(0, 99) < tx_bias);
      tx_left_i    = WD'($urandom);
      tx_right_i   = WD'($urandom);
      clr_status_i = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
